// File: rtl/sched_pkg.sv
// sched_pkg: shared decode types and constants for the dual-issue scheduler.
//   OP_R / OP_IMM / OP_LUI : supported RV32 major opcodes
//   WB_MAX                 : deepest supported issue-to-writeback latency
//   dec_t                  : per-slot decode result (register use, write, illegal)
//   wb_t                   : one write-back pipeline stage {write, rd}
package sched_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam int WB_MAX = 4;

   typedef struct packed {
      logic       use_rs1;
      logic       use_rs2;
      logic       writes;   // already excludes rd == x0
      logic       illegal;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } dec_t;

   typedef struct packed {
      logic       write;
      logic [4:0] rd;
   } wb_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of one RV32 word into register usage.
//   instr : 32-bit instruction word
//   dec   : decoded register usage, write flag and illegal flag
// The all-zero word is a plain NOP; any other unsupported opcode is a NOP that
// is flagged illegal.
module instr_decode
   import sched_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   always_comb begin
      dec         = '0;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
      if (instr != 32'h0) begin
         case (instr[6:0])
            OP_R: begin
               dec.use_rs1 = 1'b1;
               dec.use_rs2 = 1'b1;
               dec.writes  = (instr[11:7] != 5'd0);
            end
            OP_IMM: begin
               dec.use_rs1 = 1'b1;
               dec.writes  = (instr[11:7] != 5'd0);
            end
            OP_LUI: begin
               dec.writes  = (instr[11:7] != 5'd0);
            end
            default: begin
               dec.illegal = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order dual-issue scheduler with a register scoreboard
// and delayed register-file write strobes.
//   clk, rst               : clock, synchronous active-high reset
//   ins0_valid/instr0      : oldest queued instruction
//   ins1_valid/instr1      : next instruction (ignored unless ins0_valid)
//   freeze                 : external hold, nothing issues
//   pop                    : instructions consumed this cycle (combinational)
//   dp1_*/dp2_*            : registered issue strobes and words per datapath
//   wb1_*/wb2_*            : register-file write enables and addresses
//   illegal                : pulse aligned with dp*_valid for unsupported opcodes
//   dual_cnt/stall_cnt     : saturating performance counters
//   busy                   : scoreboard state, exposed for observation
//
// Handshake: the queue presents words with insX_valid; the scheduler answers
// in the same cycle with pop, and the queue drops exactly pop entries at the
// clock edge. There is no backpressure on the datapath side.
module issue_scheduler
   import sched_pkg::*;
#(
   parameter int WB_LATENCY = 2,
   parameter int CNT_W      = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ins0_valid,
   input  logic             ins1_valid,
   input  logic [31:0]      instr0,
   input  logic [31:0]      instr1,
   input  logic             freeze,
   output logic [1:0]       pop,
   output logic             dp1_valid,
   output logic             dp2_valid,
   output logic [31:0]      dp1_instr,
   output logic [31:0]      dp2_instr,
   output logic             wb1_en,
   output logic             wb2_en,
   output logic [4:0]       wb1_rd,
   output logic [4:0]       wb2_rd,
   output logic             illegal,
   output logic [CNT_W-1:0] dual_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [31:0]      busy
);

   // Legal latency is 1..WB_MAX; clamp so an out-of-range value cannot
   // produce a zero-size or oversized pipeline.
   localparam int DEPTH = (WB_LATENCY > WB_MAX) ? WB_MAX :
                          ((WB_LATENCY < 1) ? 1 : WB_LATENCY);

   dec_t        dec0;
   dec_t        dec1;
   logic        haz0;
   logic        haz1;
   logic        intra;
   logic        issue0;
   logic        issue1;
   logic [31:0] busy_next;

   wb_t wb1_pipe [DEPTH];
   wb_t wb2_pipe [DEPTH];

   instr_decode u_dec0 (.instr(instr0), .dec(dec0));
   instr_decode u_dec1 (.instr(instr1), .dec(dec1));

   // x0 is never marked busy, so x0 sources drop out of the hazard check.
   always_comb begin
      haz0 = (dec0.use_rs1 && busy[dec0.rs1]) || (dec0.use_rs2 && busy[dec0.rs2]);
      haz1 = (dec1.use_rs1 && busy[dec1.rs1]) || (dec1.use_rs2 && busy[dec1.rs2]);
      // dec0.writes implies a nonzero rd, covering both RAW and WAW in the pair.
      intra = dec0.writes &&
              ((dec1.use_rs1 && (dec1.rs1 == dec0.rd)) ||
               (dec1.use_rs2 && (dec1.rs2 == dec0.rd)) ||
               (dec1.writes  && (dec1.rd  == dec0.rd)));
      issue0 = ins0_valid && !freeze && !rst && !haz0;
      issue1 = issue0 && ins1_valid && !haz1 && !intra;
      pop    = issue1 ? 2'd2 : (issue0 ? 2'd1 : 2'd0);
   end

   // Busy is rebuilt each cycle from new issues plus every write still short
   // of its strobe stage. A register written twice in flight therefore stays
   // busy until the last of its writes has strobed.
   always_comb begin
      busy_next = '0;
      if (issue0 && dec0.writes) busy_next[dec0.rd] = 1'b1;
      if (issue1 && dec1.writes) busy_next[dec1.rd] = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (wb1_pipe[i].write) busy_next[wb1_pipe[i].rd] = 1'b1;
         if (wb2_pipe[i].write) busy_next[wb2_pipe[i].rd] = 1'b1;
      end
   end

   always_comb begin
      wb1_en = wb1_pipe[DEPTH-1].write;
      wb1_rd = wb1_pipe[DEPTH-1].rd;
      wb2_en = wb2_pipe[DEPTH-1].write;
      wb2_rd = wb2_pipe[DEPTH-1].rd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dp1_valid <= 1'b0;
         dp2_valid <= 1'b0;
         dp1_instr <= '0;
         dp2_instr <= '0;
         illegal   <= 1'b0;
         dual_cnt  <= '0;
         stall_cnt <= '0;
         busy      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            wb1_pipe[i] <= '0;
            wb2_pipe[i] <= '0;
         end
      end else begin
         dp1_valid <= issue0;
         dp2_valid <= issue1;
         dp1_instr <= issue0 ? instr0 : '0;
         dp2_instr <= issue1 ? instr1 : '0;
         illegal   <= (issue0 && dec0.illegal) || (issue1 && dec1.illegal);
         busy      <= busy_next;

         // Pipelines shift every cycle, freeze or not.
         wb1_pipe[0] <= '{write: issue0 && dec0.writes, rd: dec0.rd};
         wb2_pipe[0] <= '{write: issue1 && dec1.writes, rd: dec1.rd};
         for (int i = 1; i < DEPTH; i++) begin
            wb1_pipe[i] <= wb1_pipe[i-1];
            wb2_pipe[i] <= wb2_pipe[i-1];
         end

         if ((pop == 2'd2) && (dual_cnt != {CNT_W{1'b1}}))
            dual_cnt <= dual_cnt + 1'b1;
         if (ins0_valid && (pop == 2'd0) && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: drives issue_scheduler from a bench-side instruction
// queue and compares every cycle against a transaction-level model that keeps
// a list of pending register writes with their due cycles.
module tb_issue_scheduler;

   localparam int L  = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          ins0_valid;
   logic          ins1_valid;
   logic [31:0]   instr0;
   logic [31:0]   instr1;
   logic          freeze;
   logic [1:0]    pop;
   logic          dp1_valid;
   logic          dp2_valid;
   logic [31:0]   dp1_instr;
   logic [31:0]   dp2_instr;
   logic          wb1_en;
   logic          wb2_en;
   logic [4:0]    wb1_rd;
   logic [4:0]    wb2_rd;
   logic          illegal;
   logic [CW-1:0] dual_cnt;
   logic [CW-1:0] stall_cnt;
   logic [31:0]   busy;

   issue_scheduler #(.WB_LATENCY(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .ins0_valid(ins0_valid), .ins1_valid(ins1_valid),
      .instr0(instr0), .instr1(instr1), .freeze(freeze),
      .pop(pop),
      .dp1_valid(dp1_valid), .dp2_valid(dp2_valid),
      .dp1_instr(dp1_instr), .dp2_instr(dp2_instr),
      .wb1_en(wb1_en), .wb2_en(wb2_en), .wb1_rd(wb1_rd), .wb2_rd(wb2_rd),
      .illegal(illegal), .dual_cnt(dual_cnt), .stall_cnt(stall_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit       u1;
      bit       u2;
      bit       wr;
      bit       ill;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit [4:0] rd;
   } m_dec_t;

   typedef struct {
      int       dp;
      bit [4:0] rd;
      int       due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] prog[$];
   int          cyc = 0;
   bit          e_dpv1, e_dpv2, e_ill;
   logic [31:0] e_dpi1, e_dpi2;
   int          e_dual, e_stall;

   function automatic m_dec_t mdec(logic [31:0] w);
      m_dec_t d;
      d.u1 = 0; d.u2 = 0; d.wr = 0; d.ill = 0;
      d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7];
      if (w != 32'h0) begin
         if (w[6:0] == 7'b0110011) begin
            d.u1 = 1; d.u2 = 1; d.wr = (d.rd != 0);
         end else if (w[6:0] == 7'b0010011) begin
            d.u1 = 1; d.wr = (d.rd != 0);
         end else if (w[6:0] == 7'b0110111) begin
            d.wr = (d.rd != 0);
         end else begin
            d.ill = 1;
         end
      end
      return d;
   endfunction

   // A register is busy from the cycle after issue through its strobe cycle.
   function automatic bit is_busy(bit [4:0] r);
      foreach (pend[i]) if (pend[i].rd == r && pend[i].due >= cyc) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] t;
      bit [4:0] a, b, c;
      t = $urandom();
      a = 5'($urandom_range(0, 4));
      b = 5'($urandom_range(0, 4));
      c = 5'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
         0, 1, 2, 3: return {7'd0, b, a, 3'd0, c, 7'b0110011};
         4, 5, 6:    return {t[31:20], a, 3'd0, c, 7'b0010011};
         7:          return {t[31:12], c, 7'b0110111};
         8:          return 32'h0;
         default:    return {t[31:7], 7'b1100011};
      endcase
   endfunction

   // One clock cycle: present queue head, check all outputs, advance model.
   task automatic step(input bit frz, input bit r, input bit drop1);
      bit          v0, v1, haz0, haz1, intra, is0, is1, ewb1, ewb2;
      logic [31:0] w0, w1, ebusy;
      bit [4:0]    erd1, erd2;
      m_dec_t      d0, d1;
      int          epop;
      pend_t       keep[$];
      v0 = prog.size() > 0;
      v1 = v0 && prog.size() > 1 && !drop1;
      w0 = v0 ? prog[0] : $urandom();
      w1 = v1 ? prog[1] : $urandom();
      ins0_valid = v0; ins1_valid = v1; instr0 = w0; instr1 = w1;
      freeze = frz; rst = r;
      @(negedge clk);
      for (int i = 0; i < 32; i++) ebusy[i] = is_busy(5'(i));
      ewb1 = 0; ewb2 = 0; erd1 = 0; erd2 = 0;
      foreach (pend[i]) begin
         if (pend[i].due == cyc && pend[i].dp == 1) begin ewb1 = 1; erd1 = pend[i].rd; end
         if (pend[i].due == cyc && pend[i].dp == 2) begin ewb2 = 1; erd2 = pend[i].rd; end
      end
      d0 = mdec(w0); d1 = mdec(w1);
      haz0 = (d0.u1 && ebusy[d0.rs1]) || (d0.u2 && ebusy[d0.rs2]);
      haz1 = (d1.u1 && ebusy[d1.rs1]) || (d1.u2 && ebusy[d1.rs2]);
      intra = d0.wr && ((d1.u1 && d1.rs1 == d0.rd) || (d1.u2 && d1.rs2 == d0.rd) ||
                        (d1.wr && d1.rd == d0.rd));
      is0 = v0 && !frz && !r && !haz0;
      is1 = is0 && v1 && !haz1 && !intra;
      epop = int'(is0) + int'(is1);

      check("pop", 32'(pop), 32'(epop));
      check("dp1_valid", 32'(dp1_valid), 32'(e_dpv1));
      check("dp2_valid", 32'(dp2_valid), 32'(e_dpv2));
      if (e_dpv1) check("dp1_instr", dp1_instr, e_dpi1);
      if (e_dpv2) check("dp2_instr", dp2_instr, e_dpi2);
      check("wb1_en", 32'(wb1_en), 32'(ewb1));
      check("wb2_en", 32'(wb2_en), 32'(ewb2));
      if (ewb1) check("wb1_rd", 32'(wb1_rd), 32'(erd1));
      if (ewb2) check("wb2_rd", 32'(wb2_rd), 32'(erd2));
      check("illegal", 32'(illegal), 32'(e_ill));
      check("dual_cnt", 32'(dual_cnt), 32'(e_dual));
      check("stall_cnt", 32'(stall_cnt), 32'(e_stall));
      check("busy", busy, ebusy);

      if (r) begin
         pend.delete();
         e_dpv1 = 0; e_dpv2 = 0; e_ill = 0; e_dpi1 = 0; e_dpi2 = 0;
         e_dual = 0; e_stall = 0;
      end else begin
         e_dpv1 = is0; e_dpv2 = is1; e_dpi1 = w0; e_dpi2 = w1;
         e_ill = (is0 && d0.ill) || (is1 && d1.ill);
         if (epop == 2 && e_dual < 65535) e_dual++;
         if (v0 && epop == 0 && e_stall < 65535) e_stall++;
         foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
         pend = keep;
         if (is0 && d0.wr) pend.push_back('{dp: 1, rd: d0.rd, due: cyc + L});
         if (is1 && d1.wr) pend.push_back('{dp: 2, rd: d1.rd, due: cyc + L});
         for (int i = 0; i < epop; i++) void'(prog.pop_front());
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_step();
      prog.delete();
      step(0, 1, 0);
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; ins0_valid = 1'b0; ins1_valid = 1'b0;
      instr0 = '0; instr1 = '0;
      repeat (2) @(posedge clk);
      #1;
      e_dpv1 = 0; e_dpv2 = 0; e_ill = 0; e_dpi1 = 0; e_dpi2 = 0;
      e_dual = 0; e_stall = 0;

      // Reset state
      check("rst_dp", 32'({dp1_valid, dp2_valid, illegal}), 32'd0);
      check("rst_wb", 32'({wb1_en, wb2_en}), 32'd0);
      check("rst_cnt", 32'({dual_cnt, stall_cnt}), 32'd0);
      check("rst_busy", busy, 32'd0);

      // 1. independent pair
      reset_step();
      prog = '{32'h00500093, 32'h00700193};
      step(0, 0, 0);
      check("t1_dp_both", 32'({dp1_valid, dp2_valid}), 32'd3);
      step(0, 0, 0);
      check("t1_wb", 32'({wb1_en, wb1_rd, wb2_en, wb2_rd}), 32'({1'b1, 5'd1, 1'b1, 5'd3}));
      check("t1_dual", 32'(dual_cnt), 32'd1);
      repeat (2) step(0, 0, 0);

      // 2. RAW within pair
      reset_step();
      prog = '{32'h00500093, 32'h00108133};
      repeat (3) step(0, 0, 0);
      check("t2_stall", 32'(stall_cnt), 32'd2);
      step(0, 0, 0);
      check("t2_add_issued", dp1_instr, 32'h00108133);
      step(0, 0, 0);
      check("t2_wb_rd", 32'({wb1_en, wb1_rd}), 32'({1'b1, 5'd2}));
      step(0, 0, 0);

      // 3. WAW within pair
      reset_step();
      prog = '{32'h00500093, 32'h00500093};
      repeat (5) step(0, 0, 0);

      // 4. NOP and illegal
      reset_step();
      prog = '{32'h00000000, 32'hFFFFFFFF};
      step(0, 0, 0);
      check("t4_illegal", 32'(illegal), 32'd1);
      repeat (3) step(0, 0, 0);

      // 5a. freeze after an issue
      reset_step();
      prog = '{32'h00500093};
      step(0, 0, 0);
      prog.push_back(32'h00700193);
      repeat (3) step(1, 0, 0);
      repeat (2) step(0, 0, 0);

      // 5b. reset in flight discards pending write
      reset_step();
      prog = '{32'h00500093, 32'h00108133};
      step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      check("t5b_issue", dp1_instr, 32'h00108133);
      repeat (3) step(0, 0, 0);

      // Randomized traffic
      reset_step();
      for (int n = 0; n < 2000; n++) begin
         while (prog.size() < 3 && $urandom_range(0, 7) != 0) prog.push_back(rand_instr());
         step($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 5) == 0);
      end

      // 6. stall counter saturation
      reset_step();
      prog = '{32'h00108133};
      repeat (65534) step(1, 0, 0);
      check("t6_fffe", 32'(stall_cnt), 32'h0000FFFE);
      repeat (3) step(1, 0, 0);
      check("t6_sat", 32'(stall_cnt), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
